segmenter_qp_arbiter: RTL

- Shares one packet_segmenter input stream between NUM_QP queue-pair sources.
- Round-robin arbitration at message granularity. A grant is held from the first beat to the tlast beat, so messages are never interleaved.
- After each message the block drains the segmenter before re-arbitrating. This stops residual LCM-buffer bits from one QP being packed with another QP's data.
- Sits between the QP send queues and the segmenter input.

---
 rtl/segmenter_qp_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/segmenter_qp_arbiter.sv
// Message-granular round-robin arbiter that merges NUM_QP queue-pair AXI streams
// into one segmenter input, draining the segmenter between messages.
module segmenter_qp_arbiter #(
    parameter int NUM_QP         = 4,
    parameter int AXI_FRAME_SIZE = 128,
    parameter int MAX_MSG_BEATS  = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_QP*AXI_FRAME_SIZE-1:0]   s_axis_tdata,
    input  logic [NUM_QP-1:0]                  s_axis_tvalid,
    input  logic [NUM_QP-1:0]                  s_axis_tlast,
    output logic [NUM_QP-1:0]                  s_axis_tready,
    output logic [AXI_FRAME_SIZE-1:0]          m_axis_tdata,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    output logic [$clog2(NUM_QP)-1:0]          m_axis_tdest,
    input  logic                               m_axis_tready,
    input  logic                               seg_empty,
    output logic                               busy,
    output logic [$clog2(MAX_MSG_BEATS):0]     msg_beats,
    output logic                               err_overlong
);

    localparam int QW  = $clog2(NUM_QP);
    localparam int QW1 = QW + 1;
    localparam int MBW = $clog2(MAX_MSG_BEATS) + 1;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [QW-1:0]    grant_q, grant_d;
    logic [QW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [MBW-1:0]   msg_beats_q, msg_beats_d;
    logic             err_q, err_d;

    logic [QW:0]      rr_idx_s;
    logic [QW-1:0]    rr_pick_s;
    logic             rr_found_s;
    logic [QW-1:0]    rr_next_s;
    logic [AXI_FRAME_SIZE-1:0] sel_data_s;
    logic             sel_valid_s;
    logic             sel_last_s;

    // Round-robin search starting at rr_ptr; modulo done by conditional subtract.
    always_comb begin
        rr_found_s = 1'b0;
        rr_pick_s  = '0;
        rr_idx_s   = '0;
        for (int k = 0; k < NUM_QP; k++) begin
            rr_idx_s = {1'b0, rr_ptr_q} + QW1'(k);
            if (rr_idx_s >= QW1'(NUM_QP)) begin
                rr_idx_s = rr_idx_s - QW1'(NUM_QP);
            end else begin
                rr_idx_s = rr_idx_s;
            end
            if (!rr_found_s && s_axis_tvalid[rr_idx_s[QW-1:0]]) begin
                rr_found_s = 1'b1;
                rr_pick_s  = rr_idx_s[QW-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Granted-QP slice select and pointer advance past the current grant.
    always_comb begin
        sel_data_s  = s_axis_tdata[int'(grant_q)*AXI_FRAME_SIZE +: AXI_FRAME_SIZE];
        sel_valid_s = s_axis_tvalid[grant_q];
        sel_last_s  = s_axis_tlast[grant_q];
        if (grant_q == QW'(NUM_QP - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_q + QW'(1);
        end
    end

    // Next-state and pass-through outputs; the XFER path is purely combinational.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        msg_beats_d   = msg_beats_q;
        err_d         = err_q;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (rr_found_s) begin
                    grant_d = rr_pick_s;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_XFER: begin
                m_axis_tdata           = sel_data_s;
                m_axis_tvalid          = sel_valid_s;
                m_axis_tlast           = sel_last_s;
                s_axis_tready[grant_q] = m_axis_tready;
                if (sel_valid_s && m_axis_tready) begin
                    // msg_beats_q counts beats already taken, so this beat is the (q+1)th.
                    if (msg_beats_q >= MBW'(MAX_MSG_BEATS)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (sel_last_s) begin
                        state_d     = ST_DRAIN;
                        rr_ptr_d    = rr_next_s;
                        msg_beats_d = '0;
                    end else if (msg_beats_q != {MBW{1'b1}}) begin
                        msg_beats_d = msg_beats_q + MBW'(1);
                    end else begin
                        msg_beats_d = msg_beats_q;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DRAIN: begin
                if (seg_empty) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State, grant, pointer, beat counter and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            msg_beats_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            msg_beats_q <= msg_beats_d;
            err_q       <= err_d;
        end
    end

    assign m_axis_tdest = grant_q;
    assign busy         = (state_q != ST_ARB);
    assign msg_beats    = msg_beats_q;
    assign err_overlong = err_q;

endmodule
